// File: rtl/cmp_sort_ctrl_if.sv
// Stream bundle for cmp_sort_ctrl: a 4-bit load stream in and a sorted drain stream out.
interface cmp_sort_ctrl_if;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [3:0] out_data;
    logic       out_last;
    logic       out_ready;

    modport master (output in_valid, in_data, out_ready,
                    input  in_ready, out_valid, out_data, out_last);
    modport slave  (input  in_valid, in_data, out_ready,
                    output in_ready, out_valid, out_data, out_last);
endinterface

// File: rtl/cmp_sort_ctrl.sv
// Bubble-sorts DEPTH 4-bit values through one shared magnitude comparator, one compare per cycle.
// Optional compare counter port enabled by defining CMP_SORT_STATS_EN.
module cmp_sort_cmp4 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    output logic       o_e,
    output logic       o_g,
    output logic       o_s
);
    assign o_e = (i_a == i_b);
    assign o_g = (i_a >  i_b);
    assign o_s = (i_a <  i_b);
endmodule

module cmp_sort_ctrl #(
    parameter int DEPTH   = 4,
    parameter bit DESCEND = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    cmp_sort_ctrl_if.slave    bus,
    output logic              busy
`ifdef CMP_SORT_STATS_EN
    ,
    output logic [7:0]        cmp_count
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] LAST  = PW'(DEPTH - 1);
    localparam logic [PW-1:0] LPASS = PW'(DEPTH - 2);
    localparam logic [PW-1:0] ONE   = PW'(1);

    typedef enum logic [1:0] {S_LOAD, S_SORT, S_DRAIN} state_t;

    state_t        r_state, w_next;
    logic [3:0]    r_buf [DEPTH];
    logic [PW-1:0] r_wptr, r_rptr, r_j, r_pass;
    logic          r_swapped;

    logic [PW-1:0] w_j1;
    logic [3:0]    w_a, w_b;
    logic          w_e, w_g, w_s, w_swap;
    logic          w_in_fire, w_out_fire, w_pass_end, w_sort_done;

    assign w_j1 = r_j + ONE;
    assign w_a  = r_buf[r_j];
    assign w_b  = r_buf[w_j1];

    cmp_sort_cmp4 u_cmp (.i_a(w_a), .i_b(w_b), .o_e(w_e), .o_g(w_g), .o_s(w_s));

    // Equal keys never swap, which keeps the sort stable.
    assign w_swap      = !w_e && (DESCEND ? w_s : w_g);
    assign w_in_fire   = bus.in_valid && bus.in_ready;
    assign w_out_fire  = bus.out_valid && bus.out_ready;
    assign w_pass_end  = (r_j == (LPASS - r_pass));
    assign w_sort_done = w_pass_end && (!(r_swapped || w_swap) || (r_pass == LPASS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_LOAD;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_LOAD:  if (w_in_fire && (r_wptr == LAST))  w_next = S_SORT;
            S_SORT:  if (w_sort_done)                    w_next = S_DRAIN;
            S_DRAIN: if (w_out_fire && (r_rptr == LAST)) w_next = S_LOAD;
            default: w_next = S_LOAD;
        endcase
    end

    assign bus.in_ready  = (r_state == S_LOAD);
    assign bus.out_valid = (r_state == S_DRAIN);
    assign bus.out_data  = (r_state == S_DRAIN) ? r_buf[r_rptr] : 4'd0;
    assign bus.out_last  = (r_state == S_DRAIN) && (r_rptr == LAST);
    assign busy          = (r_state == S_SORT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_j       <= '0;
            r_pass    <= '0;
            r_swapped <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: if (w_in_fire) begin
                    r_buf[r_wptr] <= bus.in_data;
                    r_wptr        <= (r_wptr == LAST) ? '0 : r_wptr + ONE;
                    r_j           <= '0;
                    r_pass        <= '0;
                    r_swapped     <= 1'b0;
                end
                S_SORT: begin
                    if (w_swap) begin
                        r_buf[r_j]  <= w_b;
                        r_buf[w_j1] <= w_a;
                    end
                    if (w_pass_end) begin
                        r_j       <= '0;
                        r_pass    <= r_pass + ONE;
                        r_swapped <= 1'b0;
                    end else begin
                        r_j       <= w_j1;
                        r_swapped <= r_swapped || w_swap;
                    end
                end
                S_DRAIN: if (w_out_fire) r_rptr <= (r_rptr == LAST) ? '0 : r_rptr + ONE;
                default: ;
            endcase
        end
    end

`ifdef CMP_SORT_STATS_EN
    logic [7:0] r_cmp_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cmp_count <= 8'd0;
        else if ((r_state == S_LOAD) && (w_next == S_SORT))
            r_cmp_count <= 8'd0;
        else if ((r_state == S_SORT) && (r_cmp_count != 8'hFF))
            r_cmp_count <= r_cmp_count + 8'd1;
    end

    assign cmp_count = r_cmp_count;
`endif
endmodule

// File: tb/tb_cmp_sort_ctrl.sv
// Self-checking bench for cmp_sort_ctrl: directed table, reset/backpressure/back-to-back sequences, random blocks.
module tb_cmp_sort_ctrl;
    typedef logic [3:0][3:0] blk_t;
    typedef struct packed {
        blk_t       v;
        logic       desc;
        blk_t       exp;
        logic [7:0] cmps;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       tv, ro, sel;
    logic [3:0] td;

    cmp_sort_ctrl_if ifa ();
    cmp_sort_ctrl_if ifd ();
    logic busy_a, busy_d;
    logic [7:0] cc_a, cc_d;

    assign ifa.in_valid  = tv & ~sel;
    assign ifa.in_data   = td;
    assign ifa.out_ready = ro & ~sel;
    assign ifd.in_valid  = tv & sel;
    assign ifd.in_data   = td;
    assign ifd.out_ready = ro & sel;

    cmp_sort_ctrl #(.DEPTH(4), .DESCEND(1'b0)) u_asc (
        .clk(clk), .rst_n(rst_n), .bus(ifa), .busy(busy_a)
`ifdef CMP_SORT_STATS_EN
        , .cmp_count(cc_a)
`endif
    );
    cmp_sort_ctrl #(.DEPTH(4), .DESCEND(1'b1)) u_dsc (
        .clk(clk), .rst_n(rst_n), .bus(ifd), .busy(busy_d)
`ifdef CMP_SORT_STATS_EN
        , .cmp_count(cc_d)
`endif
    );
`ifndef CMP_SORT_STATS_EN
    assign cc_a = 8'd0;
    assign cc_d = 8'd0;
`endif

    logic       m_in_ready, m_out_valid, m_out_last, m_busy;
    logic [3:0] m_out_data;
    logic [7:0] m_cc;
    assign m_in_ready  = sel ? ifd.in_ready  : ifa.in_ready;
    assign m_out_valid = sel ? ifd.out_valid : ifa.out_valid;
    assign m_out_last  = sel ? ifd.out_last  : ifa.out_last;
    assign m_out_data  = sel ? ifd.out_data  : ifa.out_data;
    assign m_busy      = sel ? busy_d        : busy_a;
    assign m_cc        = sel ? cc_d          : cc_a;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Counting sort by key: equal keys come out in arrival order.
    task automatic model_sort(input blk_t v, input bit desc, output blk_t o);
        int k = 0;
        o = '0;
        for (int x = 0; x < 16; x++) begin
            int key = desc ? 15 - x : x;
            for (int i = 0; i < 4; i++)
                if (int'(v[i]) == key) begin o[k] = v[i]; k++; end
        end
    endtask

    // Passes that swap = max count of out-of-order predecessors of any element; one clean pass ends it early.
    function automatic int model_cmps(input blk_t v, input bit desc);
        int kmax = 0, np, sum = 0;
        for (int i = 0; i < 4; i++) begin
            int c = 0;
            for (int j = 0; j < i; j++)
                if (desc ? (v[j] < v[i]) : (v[j] > v[i])) c++;
            if (c > kmax) kmax = c;
        end
        np = (kmax + 1 < 3) ? kmax + 1 : 3;
        for (int p = 0; p < np; p++) sum += 3 - p;
        return sum;
    endfunction

    task automatic send(input logic [3:0] d);
        int w = 0;
        tv = 1'b1;
        td = d;
        while (!m_in_ready && w < 100) begin w++; @(negedge clk); end
        if (w >= 100) chk("send timeout", w, 0);
        @(negedge clk);
    endtask

    task automatic drain(input blk_t exp, input int mode, input string nm);
        int beats = 0, cyc = 0, unstable = 0, ir_bad = 0;
        bit stalled = 1'b0;
        logic [3:0] held = 4'd0;
        logic [6:0] pat = 7'b1011001;  // bit k = out_ready in cycle k: 1,0,0,1,1,0,1
        while (beats < 4 && cyc < 200) begin
            case (mode)
                1:       ro = (cyc < 7) ? pat[cyc] : 1'b1;
                2:       ro = ($urandom_range(0, 3) != 0);
                default: ro = 1'b1;
            endcase
            if (m_in_ready) ir_bad++;
            if (m_out_valid) begin
                if (stalled && m_out_data != held) unstable++;
                if (ro) begin
                    chk({nm, " data"}, int'(m_out_data), int'(exp[beats]));
                    chk({nm, " last"}, int'(m_out_last), int'(beats == 3));
                    beats++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = m_out_data;
                end
            end
            cyc++;
            @(negedge clk);
        end
        ro = 1'b0;
        chk({nm, " beats"}, beats, 4);
        chk({nm, " stall stable"}, unstable, 0);
        chk({nm, " in_ready low in drain"}, ir_bad, 0);
        chk({nm, " in_ready after last"}, int'(m_in_ready), 1);
        chk({nm, " out_valid after last"}, int'(m_out_valid), 0);
    endtask

    task automatic run_block(input blk_t v, input bit desc, input blk_t exp, input int ecmp,
                             input int mode, input bit hold, input logic [3:0] nd, input string nm);
        int cnt = 0, ir_bad = 0;
        sel = desc;
        for (int i = 0; i < 4; i++) send(v[i]);
        if (hold) td = nd;
        else      tv = 1'b0;
        while (m_busy && cnt < 100) begin
            if (m_in_ready) ir_bad++;
            cnt++;
            @(negedge clk);
        end
        chk({nm, " busy cycles"}, cnt, ecmp);
        chk({nm, " in_ready low in sort"}, ir_bad, 0);
        chk({nm, " out_valid after sort"}, int'(m_out_valid), 1);
`ifdef CMP_SORT_STATS_EN
        chk({nm, " cmp_count"}, int'(m_cc), ecmp);
`endif
        drain(exp, mode, nm);
    endtask

    task automatic set_vec(output vec_t t, input logic [3:0] a0, a1, a2, a3, input bit desc,
                           input logic [3:0] e0, e1, e2, e3, input int cmps);
        t.v[0] = a0; t.v[1] = a1; t.v[2] = a2; t.v[3] = a3;
        t.exp[0] = e0; t.exp[1] = e1; t.exp[2] = e2; t.exp[3] = e3;
        t.desc = desc;
        t.cmps = 8'(cmps);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        blk_t v, e;
        set_vec(tbl[0], 4, 3, 2, 1,  1'b0, 1, 2, 3, 4,   6);
        set_vec(tbl[1], 9, 7, 3, 0,  1'b0, 0, 3, 7, 9,   6);
        set_vec(tbl[2], 1, 2, 5, 15, 1'b0, 1, 2, 5, 15,  3);
        set_vec(tbl[3], 5, 5, 0, 15, 1'b0, 0, 5, 5, 15,  6);
        set_vec(tbl[4], 5, 5, 0, 15, 1'b1, 15, 5, 5, 0,  6);
        set_vec(tbl[5], 1, 2, 5, 15, 1'b1, 15, 5, 2, 1,  6);

        rst_n = 1'b0; tv = 1'b0; td = 4'd0; ro = 1'b0; sel = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst in_ready", int'(ifa.in_ready), 1);
        chk("rst out_valid", int'(ifa.out_valid), 0);
        chk("rst out_data", int'(ifa.out_data), 0);
        chk("rst out_last", int'(ifa.out_last), 0);
        chk("rst busy", int'(busy_a), 0);
        chk("rst d in_ready", int'(ifd.in_ready), 1);
`ifdef CMP_SORT_STATS_EN
        chk("rst cmp_count", int'(cc_a), 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Reset mid-load discards the partial block.
        send(4'd7);
        send(4'd6);
        tv = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("midload rst in_ready", int'(m_in_ready), 1);
        chk("midload rst out_valid", int'(m_out_valid), 0);
        chk("midload rst busy", int'(m_busy), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++)
            run_block(tbl[i].v, tbl[i].desc, tbl[i].exp, int'(tbl[i].cmps), 0, 1'b0, 4'd0,
                      $sformatf("vec%0d", i));

        // Backpressure during drain.
        run_block(tbl[1].v, 1'b0, tbl[1].exp, 6, 1, 1'b0, 4'd0, "bp");

        // Back-to-back blocks with in_valid held high.
        v[0] = 8; v[1] = 4; v[2] = 2; v[3] = 1;
        e[0] = 1; e[1] = 2; e[2] = 4; e[3] = 8;
        run_block(v, 1'b0, e, 6, 0, 1'b1, 4'd3, "b2b first");
        v[0] = 3; v[1] = 3; v[2] = 3; v[3] = 0;
        e[0] = 0; e[1] = 3; e[2] = 3; e[3] = 3;
        run_block(v, 1'b0, e, 6, 0, 1'b0, 4'd0, "b2b second");

        // Random blocks against the reference model.
        for (int n = 0; n < 24; n++) begin
            bit d;
            for (int i = 0; i < 4; i++) v[i] = 4'($urandom_range(0, 15));
            if (n % 5 == 0) v[2] = v[0];
            d = 1'($urandom_range(0, 1));
            model_sort(v, d, e);
            run_block(v, d, e, model_cmps(v, d), 2, 1'b0, 4'd0, $sformatf("rand%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
